// File: rtl/axi_mem_master.sv
// axi_mem_master: bridges the core's single-request memory port to one AXI4 slave.
// Exactly one transaction is outstanding at a time. Reads are INCR bursts of
// req_len+1 beats whose R beats pass straight through to the core's response port.
// Writes are single-beat, strobed transfers whose B response becomes one core response.
//
// Ports
//   ACLK, ARESET                      clock; asynchronous active-high reset
//   req_valid/req_ready/req_wr/...    core request (addr, len, wdata, wstrb)
//   rsp_valid/rsp_ready/rsp_rdata/... core response (last, err)
//   AR*, R*, AW*, W*, B*              AXI4 master channels
module axi_mem_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned LEN_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int unsigned STRB_W   = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // core request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  // core response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_err,
  // AR channel
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [2:0]        ARPROT,
  // R channel
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  // AW channel
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic [2:0]        AWPROT,
  // W channel
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  // B channel
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP
);

  localparam logic [2:0] BusSize = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {StIdle, StRdAr, StRdData, StWrReq, StWrResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                last_beat;
  logic                aw_fire, w_fire;

  // Only the error bit of each response code matters; OKAY and EXOKAY both pass.
  logic unused_resp;
  assign unused_resp = ^{RRESP[0], BRESP[0]};

  // Request fields are held in registers for the whole transaction.
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(len_q);
  assign ARSIZE  = BusSize;
  assign ARBURST = 2'b01;
  assign ARPROT  = 3'b000;
  assign AWADDR  = addr_q;
  assign AWSIZE  = BusSize;
  assign AWBURST = 2'b01;
  assign AWPROT  = 3'b000;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // State is already StIdle while reset is held, so gate the ready explicitly.
        req_ready = ~ARESET;
        if (req_valid && !ARESET) begin
          addr_d    = req_addr;
          len_d     = req_len;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wr ? StWrReq : StRdAr;
        end
      end
      StRdAr: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = StRdData;
      end
      StRdData: begin
        rsp_valid = RVALID;
        RREADY    = rsp_ready;
        rsp_rdata = RDATA;
        rsp_last  = last_beat;
        // A misplaced RLAST is flagged, but the beat count alone decides the exit.
        rsp_err   = RRESP[1] | (RLAST ^ last_beat);
        if (RVALID && rsp_ready) begin
          if (last_beat) state_d = StIdle;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      StWrReq: begin
        AWVALID   = ~aw_done_q;
        WVALID    = ~w_done_q;
        aw_fire   = AWVALID & AWREADY;
        w_fire    = WVALID & WREADY;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        BREADY    = rsp_ready;
        rsp_valid = BVALID;
        rsp_last  = 1'b1;
        rsp_err   = BRESP[1];
        if (BVALID && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master: a table of read/write transactions with
// hand-chosen slave timing, plus a hand-written mid-burst reset sequence.
module tb_axi_mem_master;

  localparam int LW = 3;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [LW-1:0] req_len;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [63:0] rsp_rdata;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST;
  logic        RVALID, RREADY, RLAST;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWSIZE, AWPROT;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY, WLAST;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;

  int n_chk = 0;
  int n_err = 0;

  axi_mem_master #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    logic [63:0] data;
    logic [7:0]  strb;
    int          ar_wait;
    int          aw_wait;
    int          w_wait;
    int          b_wait;
    logic [1:0]  bresp;
    int          err_beat;   // read beat given RRESP=SLVERR, -1 for none
    int          last_beat;  // read beat carrying RLAST
    bit          gaps;       // RVALID bubbles
    bit          toggle;     // rsp_ready toggling
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic slave_idle();
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; rsp_ready = 1'b0;
  endtask

  task automatic read_txn(input vec_t v, input string nm);
    int   b = 0;
    int   cyc = 0;
    logic rv;
    logic exp_err;
    @(negedge ACLK);
    slave_idle();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = v.addr; req_len = v.len[LW-1:0];
    req_wdata = '1; req_wstrb = '1;
    #1;
    chk({nm, ".req_ready"}, req_ready, 1'b1);
    chk({nm, ".arvalid_accept_cycle"}, ARVALID, 1'b0);
    for (int t = 0; t <= v.ar_wait; t++) begin
      @(negedge ACLK);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      ARREADY   = (t == v.ar_wait);
      #1;
      chk($sformatf("%s.ar%0d.arvalid", nm, t), ARVALID, 1'b1);
      chk($sformatf("%s.ar%0d.araddr", nm, t), ARADDR, v.addr);
      chk($sformatf("%s.ar%0d.arlen", nm, t), ARLEN, 8'(v.len));
      chk($sformatf("%s.ar%0d.arattr", nm, t), {ARSIZE, ARBURST, ARPROT},
          {3'd3, 2'b01, 3'b000});
      chk($sformatf("%s.ar%0d.rready", nm, t), RREADY, 1'b0);
      chk($sformatf("%s.ar%0d.req_ready", nm, t), req_ready, 1'b0);
    end
    while (b <= v.len && cyc < 100) begin
      @(negedge ACLK);
      ARREADY   = 1'b0;
      rv        = !(v.gaps && (cyc % 3 == 1));
      RVALID    = rv;
      RDATA     = v.data + 64'(b);
      RRESP     = (b == v.err_beat) ? 2'b10 : 2'b00;
      RLAST     = (b == v.last_beat);
      rsp_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk($sformatf("%s.c%0d.rsp_valid", nm, cyc), rsp_valid, rv);
      chk($sformatf("%s.c%0d.rready", nm, cyc), RREADY, rsp_ready);
      if (rv) begin
        exp_err = (b == v.err_beat) || ((b == v.last_beat) != (b == v.len));
        chk($sformatf("%s.b%0d.rdata", nm, b), rsp_rdata, v.data + 64'(b));
        chk($sformatf("%s.b%0d.last", nm, b), rsp_last, (b == v.len));
        chk($sformatf("%s.b%0d.err", nm, b), rsp_err, exp_err);
      end
      if (rv && rsp_ready) b++;
      cyc++;
    end
    chk({nm, ".beats"}, 64'(b), 64'(v.len + 1));
  endtask

  task automatic write_txn(input vec_t v, input string nm);
    bit awd = 1'b0;
    bit wd = 1'b0;
    bit done = 1'b0;
    int t = 0;
    @(negedge ACLK);
    slave_idle();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = v.addr; req_len = '0;
    req_wdata = v.data; req_wstrb = v.strb;
    #1;
    chk({nm, ".req_ready"}, req_ready, 1'b1);
    chk({nm, ".valid_accept_cycle"}, {AWVALID, WVALID}, 2'b00);
    while (!(awd && wd) && t < 50) begin
      @(negedge ACLK);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      AWREADY   = (t >= v.aw_wait);
      WREADY    = (t >= v.w_wait);
      #1;
      chk($sformatf("%s.t%0d.awvalid", nm, t), AWVALID, !awd);
      chk($sformatf("%s.t%0d.wvalid", nm, t), WVALID, !wd);
      chk($sformatf("%s.t%0d.awaddr", nm, t), AWADDR, v.addr);
      chk($sformatf("%s.t%0d.wdata", nm, t), WDATA, v.data);
      chk($sformatf("%s.t%0d.wstrb_wlast", nm, t), {WSTRB, WLAST}, {v.strb, 1'b1});
      chk($sformatf("%s.t%0d.awattr", nm, t), {AWSIZE, AWBURST, AWPROT},
          {3'd3, 2'b01, 3'b000});
      chk($sformatf("%s.t%0d.bready", nm, t), BREADY, 1'b0);
      if (t >= v.aw_wait) awd = 1'b1;
      if (t >= v.w_wait) wd = 1'b1;
      t++;
    end
    t = 0;
    while (!done && t < 50) begin
      @(negedge ACLK);
      AWREADY   = 1'b0;
      WREADY    = 1'b0;
      BVALID    = (t >= v.b_wait);
      BRESP     = v.bresp;
      rsp_ready = v.toggle ? (t > v.b_wait) : 1'b1;
      #1;
      chk($sformatf("%s.b%0d.rsp_valid", nm, t), rsp_valid, BVALID);
      chk($sformatf("%s.b%0d.bready", nm, t), BREADY, rsp_ready);
      chk($sformatf("%s.b%0d.aw_w_idle", nm, t), {AWVALID, WVALID}, 2'b00);
      if (BVALID) begin
        chk($sformatf("%s.b%0d.last", nm, t), rsp_last, 1'b1);
        chk($sformatf("%s.b%0d.rdata", nm, t), rsp_rdata, 64'h0);
        chk($sformatf("%s.b%0d.err", nm, t), rsp_err, v.bresp[1]);
      end
      done = BVALID && rsp_ready;
      t++;
    end
    chk({nm, ".bdone"}, done, 1'b1);
  endtask

  initial begin
    vecs[0] = '{0, 32'h8000_0000, 0, 64'h1122_3344_5566_7788, 8'h00, 0, 0, 0, 0, 2'b00, -1, 0, 0, 0};
    vecs[1] = '{0, 32'h8000_0040, 7, 64'hA5A5_0000_0000_1000, 8'h00, 2, 0, 0, 0, 2'b00, -1, 7, 1, 1};
    vecs[2] = '{1, 32'h8000_0100, 0, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 0, 3, 0, 1, 2'b00, -1, 0, 0, 1};
    vecs[3] = '{0, 32'h8000_0200, 3, 64'h0101_0101_0000_0000, 8'h00, 1, 0, 0, 0, 2'b00, 1, 3, 0, 0};
    vecs[4] = '{0, 32'h8000_0300, 3, 64'h0202_0202_0000_0000, 8'h00, 0, 0, 0, 0, 2'b00, -1, 1, 0, 0};
    vecs[5] = '{1, 32'h8000_0400, 0, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 0, 0, 0, 2'b11, -1, 0, 0, 0};
    vecs[6] = '{0, 32'h8000_0500, 2, 64'h0303_0303_0000_0000, 8'h00, 0, 0, 0, 0, 2'b00, -1, 2, 0, 0};
    vecs[7] = '{1, 32'h8000_0508, 0, 64'hFFEE_DDCC_BBAA_9988, 8'hFF, 0, 0, 0, 0, 2'b00, -1, 0, 0, 0};
    vecs[8] = '{1, 32'h8000_0600, 0, 64'h5555_AAAA_5555_AAAA, 8'h3C, 0, 0, 2, 2, 2'b01, -1, 0, 0, 1};

    // Reset state, with slave valids and rsp_ready high to prove the gating.
    ARESET = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; req_wstrb = '0;
    slave_idle();
    RVALID = 1'b1; BVALID = 1'b1; ARREADY = 1'b1; rsp_ready = 1'b1;
    @(negedge ACLK);
    #1;
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.valids", {ARVALID, AWVALID, WVALID, rsp_valid}, 4'b0000);
    chk("rst.readies", {RREADY, BREADY}, 2'b00);
    chk("rst.araddr", ARADDR, 32'h0);
    @(negedge ACLK);
    ARESET = 1'b0;
    slave_idle();
    #1;
    chk("rst.release_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) write_txn(vecs[i], $sformatf("v%0d", i));
      else            read_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted while beat 3 of a 4-beat read is on the bus.
    @(negedge ACLK);
    slave_idle();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h9000_0000; req_len = 3'd3;
    @(negedge ACLK);
    req_valid = 1'b0; ARREADY = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge ACLK);
      ARREADY = 1'b0; RVALID = 1'b1; RDATA = 64'h77 + 64'(b); RLAST = 1'b0; rsp_ready = 1'b1;
    end
    #1;
    chk("abort.beat3_valid", rsp_valid, 1'b1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("abort.valids", {ARVALID, AWVALID, WVALID, rsp_valid}, 4'b0000);
    chk("abort.readies", {RREADY, BREADY}, 2'b00);
    chk("abort.req_ready", req_ready, 1'b0);
    chk("abort.regs", {ARADDR, ARLEN}, 40'h0);
    @(negedge ACLK);
    #1;
    chk("abort.req_ready_held", req_ready, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("abort.release_req_ready", req_ready, 1'b1);
    chk("abort.no_stale_rsp", {rsp_valid, RREADY}, 2'b00);

    // Normal operation after the aborted burst.
    read_txn(vecs[6], "post_abort");

    @(negedge ACLK);
    slave_idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
